// File: rtl/ibm_sched.sv
// Scheduler around the Berlekamp-Massey core: credit-based frame admission, core
// sequencing with timeout, zero-syndrome bypass and a 2-entry in-order sigma FIFO.
module ibm_sched #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_syn_valid,
  output logic        o_syn_ready,
  input  logic [1:0]  i_syn_code,
  input  logic        i_syn_mode,
  input  logic [79:0] i_syn_data,
  output logic        o_ibm_clear_and_wen,
  output logic [1:0]  o_ibm_code,
  output logic        o_ibm_mode,
  output logic [79:0] o_ibm_S,
  input  logic        i_ibm_next_S,
  input  logic        i_ibm_valid,
  input  logic [79:0] i_ibm_sigma,
  output logic        o_sig_valid,
  input  logic        i_sig_ready,
  output logic [79:0] o_sig_data,
  output logic [1:0]  o_sig_code,
  output logic        o_sig_bypass,
  output logic        o_err_code,
  output logic        o_err_timeout,
  output logic        o_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  localparam logic [1:0]       CODE_1023    = 2'b10;
  localparam logic [1:0]       CODE_ILLEGAL = 2'b11;
  localparam logic [CNT_W-1:0] TIMER_LAST   = CNT_W'(TIMEOUT - 1);

  state_t           r_state, w_state_n;
  logic [CNT_W-1:0] r_timer;
  logic [1:0]       r_inflight;
  logic [1:0]       r_inf_code [2];
  logic [79:0]      r_ibm_S;
  logic [1:0]       r_ibm_code;
  logic             r_ibm_mode;
  logic             r_err_code, r_err_to;

  logic [1:0]       r_cnt, w_cnt_n;
  logic [79:0]      r_dat [2];
  logic [79:0]      w_dat_n [2];
  logic [1:0]       r_cod [2];
  logic [1:0]       w_cod_n [2];
  logic             r_byp [2];
  logic             w_byp_n [2];

  logic             w_illegal, w_zero, w_credit, w_accept;
  logic             w_acc_bad, w_acc_byp, w_acc_core;
  logic             w_issue, w_timeout, w_cap, w_pop;
  logic [79:0]      w_cap_data;

  assign w_illegal = (i_syn_code == CODE_ILLEGAL);
  assign w_zero    = (i_syn_data == '0);
  assign w_credit  = ({1'b0, r_inflight} + {1'b0, r_cnt}) < 3'd2;
  // A bypass frame must not overtake a frame still inside the core.
  assign o_syn_ready = (r_state == ST_IDLE) && w_credit
                       && !(w_zero && !w_illegal && (r_inflight != 2'd0));
  assign w_accept   = i_syn_valid && o_syn_ready;
  assign w_acc_bad  = w_accept && w_illegal;
  assign w_acc_byp  = w_accept && !w_illegal && w_zero;
  assign w_acc_core = w_accept && !w_illegal && !w_zero;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    w_state_n = r_state;
    w_issue   = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_acc_core) w_state_n = ST_ISSUE;
      ST_ISSUE: begin
        w_issue   = 1'b1;
        w_state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_ibm_next_S) begin
          w_state_n = ST_IDLE;
        end else if (r_timer == TIMER_LAST) begin
          w_timeout = 1'b1;
          w_state_n = ST_IDLE;
        end
      end
      default:  w_state_n = ST_IDLE;
    endcase
  end

  // Sigma belongs to the oldest frame in the core; its code selects which fields are unused.
  assign w_cap = i_ibm_valid && (r_inflight != 2'd0);

  always_comb begin
    w_cap_data = i_ibm_sigma;
    if (r_inf_code[0] == CODE_1023) w_cap_data[29:0]  = '0;
    else                            w_cap_data[49:30] = '0;
  end

  assign w_pop = (r_cnt != 2'd0) && i_sig_ready;

  // Pop shifts the head out first; a core result lands ahead of a bypass result in the same cycle.
  always_comb begin
    w_dat_n = r_dat;
    w_cod_n = r_cod;
    w_byp_n = r_byp;
    w_cnt_n = r_cnt;
    if (w_pop) begin
      w_dat_n[0] = r_dat[1];
      w_cod_n[0] = r_cod[1];
      w_byp_n[0] = r_byp[1];
      w_cnt_n    = r_cnt - 2'd1;
    end
    if (w_cap && (w_cnt_n < 2'd2)) begin
      w_dat_n[w_cnt_n[0]] = w_cap_data;
      w_cod_n[w_cnt_n[0]] = r_inf_code[0];
      w_byp_n[w_cnt_n[0]] = 1'b0;
      w_cnt_n             = w_cnt_n + 2'd1;
    end
    if (w_acc_byp && (w_cnt_n < 2'd2)) begin
      w_dat_n[w_cnt_n[0]] = {10'd1, 70'd0};
      w_cod_n[w_cnt_n[0]] = i_syn_code;
      w_byp_n[w_cnt_n[0]] = 1'b1;
      w_cnt_n             = w_cnt_n + 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      r_inflight    <= '0;
      r_inf_code[0] <= '0;
      r_inf_code[1] <= '0;
      r_ibm_S       <= '0;
      r_ibm_code    <= '0;
      r_ibm_mode    <= 1'b0;
      r_err_code    <= 1'b0;
      r_err_to      <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (w_issue)                  r_timer <= '0;
      else if (r_state == ST_WAIT)  r_timer <= r_timer + 1'b1;
      if (w_acc_core) begin
        r_ibm_S    <= i_syn_data;
        r_ibm_code <= i_syn_code;
        r_ibm_mode <= i_syn_mode;
      end
      if (w_timeout) r_inflight <= '0;
      else           r_inflight <= r_inflight + {1'b0, w_issue} - {1'b0, w_cap};
      if (w_cap)   r_inf_code[0] <= r_inf_code[1];
      if (w_issue) r_inf_code[r_inflight[0] & ~w_cap] <= r_ibm_code;
      r_err_code <= w_acc_bad;
      r_err_to   <= r_err_to | w_timeout;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: FIFO storage is reset too because the head entry drives o_sig_* directly.
    if (i_rst) begin
      r_cnt <= '0;
      r_dat <= '{default: '0};
      r_cod <= '{default: '0};
      r_byp <= '{default: 1'b0};
    end else begin
      r_cnt <= w_cnt_n;
      r_dat <= w_dat_n;
      r_cod <= w_cod_n;
      r_byp <= w_byp_n;
    end
  end

  assign o_ibm_clear_and_wen = w_issue;
  assign o_ibm_S             = r_ibm_S;
  assign o_ibm_code          = r_ibm_code;
  assign o_ibm_mode          = r_ibm_mode;
  assign o_sig_valid         = (r_cnt != 2'd0);
  assign o_sig_data          = r_dat[0];
  assign o_sig_code          = r_cod[0];
  assign o_sig_bypass        = r_byp[0];
  assign o_err_code          = r_err_code;
  assign o_err_timeout       = r_err_to | w_timeout;
  assign o_busy              = (r_state != ST_IDLE) || (r_inflight != 2'd0);

endmodule
